// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-entry FIFO control core: geometry, status
// state encoding and the register-bank one-hot helper.
package fifo_pkg;

   localparam int unsigned AW    = 3;
   localparam int unsigned DEPTH = 8;

   localparam logic [AW:0] CNT_EMPTY = (AW+1)'(0);
   localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
   localparam logic [AW:0] CNT_FULL  = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WRITE    = 3'd1,
      READ     = 3'd2,
      RDWR     = 3'd3,
      WR_ERR   = 3'd4,
      RD_ERR   = 3'd5,
      RDWR_ERR = 3'd6
   } fifo_state_t;

   function automatic logic [DEPTH-1:0] onehot(input logic [AW-1:0] idx);
      logic [DEPTH-1:0] one_s;
      one_s  = {{(DEPTH-1){1'b0}}, 1'b1};
      onehot = one_s << idx;
   endfunction

endpackage

// File: rtl/fifo_controller_if.sv
// Request/status bundle between the FIFO top level and its control core.
interface fifo_controller_if;
   import fifo_pkg::*;

   logic             wr_en;
   logic             rd_en;
   logic [DEPTH-1:0] reg_we;
   logic [AW-1:0]    rd_addr;
   logic             dout_load;
   logic             full;
   logic             empty;
   logic [AW:0]      data_count;
   logic             wr_ack;
   logic             wr_err;
   logic             rd_ack;
   logic             rd_err;

   modport master (
      output wr_en, rd_en,
      input  reg_we, rd_addr, dout_load, full, empty, data_count,
      input  wr_ack, wr_err, rd_ack, rd_err
   );

   modport slave (
      input  wr_en, rd_en,
      output reg_we, rd_addr, dout_load, full, empty, data_count,
      output wr_ack, wr_err, rd_ack, rd_err
   );
endinterface

// File: rtl/fifo_ns_logic.sv
// Next-state logic of the FIFO control core: accept decisions, pointer and
// occupancy updates, and the status state for the following cycle.
module fifo_ns_logic
   import fifo_pkg::*;
(
   input  logic [AW-1:0] head,
   input  logic [AW-1:0] tail,
   input  logic [AW:0]   count,
   input  logic          full,
   input  logic          empty,
   input  logic          wr_en,
   input  logic          rd_en,
   output logic          wr_ok,
   output logic          rd_ok,
   output logic [AW-1:0] head_nxt,
   output logic [AW-1:0] tail_nxt,
   output logic [AW:0]   count_nxt,
   output fifo_state_t   state_nxt
);

   logic wr_rej_s;
   logic rd_rej_s;

   assign wr_ok    = wr_en & ~full;
   assign rd_ok    = rd_en & ~empty;
   assign wr_rej_s = wr_en & full;
   assign rd_rej_s = rd_en & empty;

   // Pointer and occupancy updates; pointers wrap naturally at AW bits.
   always_comb begin
      head_nxt  = head;
      tail_nxt  = tail;
      count_nxt = count;
      if (wr_ok) begin
         tail_nxt = tail + {{(AW-1){1'b0}}, 1'b1};
      end else begin
         tail_nxt = tail;
      end
      if (rd_ok) begin
         head_nxt = head + {{(AW-1){1'b0}}, 1'b1};
      end else begin
         head_nxt = head;
      end
      case ({wr_ok, rd_ok})
         2'b10:   count_nxt = count + CNT_ONE;
         2'b01:   count_nxt = count - CNT_ONE;
         default: count_nxt = count;
      endcase
   end

   // Status state: the tuple of what happened to this cycle's requests.
   always_comb begin
      state_nxt = IDLE;
      if (wr_ok && rd_ok) begin
         state_nxt = RDWR;
      end else if ((wr_ok && rd_rej_s) || (rd_ok && wr_rej_s)) begin
         state_nxt = RDWR_ERR;
      end else if (wr_ok) begin
         state_nxt = WRITE;
      end else if (rd_ok) begin
         state_nxt = READ;
      end else if (wr_rej_s) begin
         state_nxt = WR_ERR;
      end else if (rd_rej_s) begin
         state_nxt = RD_ERR;
      end else begin
         state_nxt = IDLE;
      end
   end

endmodule

// File: rtl/fifo_controller.sv
// Control core of the 8 x 32 FIFO: holds head/tail/count/status registers and
// decodes bank write enables, read-mux select and request status.
module fifo_controller
   import fifo_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   fifo_controller_if.slave  bus
);

   logic [AW-1:0] head_r;
   logic [AW-1:0] tail_r;
   logic [AW:0]   count_r;
   fifo_state_t   state_r;

   logic [AW-1:0] head_nxt_s;
   logic [AW-1:0] tail_nxt_s;
   logic [AW:0]   count_nxt_s;
   fifo_state_t   state_nxt_s;
   logic          wr_ok_s;
   logic          rd_ok_s;
   logic          full_s;
   logic          empty_s;

   assign full_s  = (count_r == CNT_FULL);
   assign empty_s = (count_r == CNT_EMPTY);

   fifo_ns_logic u_ns (
      .head      (head_r),
      .tail      (tail_r),
      .count     (count_r),
      .full      (full_s),
      .empty     (empty_s),
      .wr_en     (bus.wr_en),
      .rd_en     (bus.rd_en),
      .wr_ok     (wr_ok_s),
      .rd_ok     (rd_ok_s),
      .head_nxt  (head_nxt_s),
      .tail_nxt  (tail_nxt_s),
      .count_nxt (count_nxt_s),
      .state_nxt (state_nxt_s)
   );

   // Core state registers; reset wins over any request in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_r  <= {AW{1'b0}};
         tail_r  <= {AW{1'b0}};
         count_r <= CNT_EMPTY;
         state_r <= IDLE;
      end else begin
         head_r  <= head_nxt_s;
         tail_r  <= tail_nxt_s;
         count_r <= count_nxt_s;
         state_r <= state_nxt_s;
      end
   end

   assign bus.rd_addr    = head_r;
   assign bus.dout_load  = rd_ok_s;
   assign bus.full       = full_s;
   assign bus.empty      = empty_s;
   assign bus.data_count = count_r;

   // Bank write enable for the slot at the tail.
   always_comb begin
      if (wr_ok_s) begin
         bus.reg_we = onehot(tail_r);
      end else begin
         bus.reg_we = {DEPTH{1'b0}};
      end
   end

   // Moore status decode. RDWR_ERR only follows a simultaneous request at an
   // extreme: a write into empty leaves exactly one entry, a read from full
   // leaves DEPTH-1, so the occupancy tells the two cases apart.
   always_comb begin
      bus.wr_ack = 1'b0;
      bus.wr_err = 1'b0;
      bus.rd_ack = 1'b0;
      bus.rd_err = 1'b0;
      case (state_r)
         IDLE:   bus.wr_ack = 1'b0;
         WRITE:  bus.wr_ack = 1'b1;
         READ:   bus.rd_ack = 1'b1;
         RDWR: begin
            bus.wr_ack = 1'b1;
            bus.rd_ack = 1'b1;
         end
         WR_ERR: bus.wr_err = 1'b1;
         RD_ERR: bus.rd_err = 1'b1;
         RDWR_ERR: begin
            if (count_r == CNT_ONE) begin
               bus.wr_ack = 1'b1;
               bus.rd_err = 1'b1;
            end else begin
               bus.rd_ack = 1'b1;
               bus.wr_err = 1'b1;
            end
         end
         default: bus.wr_ack = 1'b0;
      endcase
   end

endmodule
